// File: rtl/gnrl_dconv_pkg.sv
// gnrl_dconv_pkg: shared definitions for the gnrl_dconv_accum downconverter.
//   - state_e      : converter state encoding (IDLE, RUN)
//   - LO_SIGN_TBL  : fs/4 sign-only LO table indexed by effective phase,
//                    bit 1 = negate I, bit 0 = negate Q
//   - acc_width_ok : width sanity check, accumulator must hold ADC_WIDTH+2 bits
package gnrl_dconv_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Phase 0:(+,+) 1:(+,-) 2:(-,-) 3:(-,+); entry [3] is the leftmost element.
  localparam logic [3:0][1:0] LO_SIGN_TBL = {2'b10, 2'b11, 2'b01, 2'b00};

  function automatic bit acc_width_ok(input int acc_w, input int adc_w);
    return acc_w >= adc_w + 2;
  endfunction

endpackage

// File: rtl/gnrl_dconv_mixer.sv
// gnrl_dconv_mixer: DC removal, LO phase counter and sign application.
// Produces registered I/Q products plus an accept flag and a block-end tag.
// Ports:
//   CLK, RESET      clock, asynchronous active-high reset
//   clr             clear phase counter and pipeline (converter disabled)
//   accept          sample accepted this cycle
//   last            accepted sample is the final one of its block
//   adc_data_in     unsigned ADC sample
//   dc_subtractor   signed DC offset
//   lo_phase_ofs    LO phase offset in 90 degree steps
//   prod_i_p1/q_p1  registered signed products (ADC_WIDTH+2 bits)
//   vld_p1, last_p1 registered accept flag and block-end tag
module gnrl_dconv_mixer
  import gnrl_dconv_pkg::*;
#(
  parameter int ADC_WIDTH = 14
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        clr,
  input  logic                        accept,
  input  logic                        last,
  input  logic        [ADC_WIDTH-1:0] adc_data_in,
  input  logic signed [ADC_WIDTH:0]   dc_subtractor,
  input  logic        [1:0]           lo_phase_ofs,
  output logic signed [ADC_WIDTH+1:0] prod_i_p1,
  output logic signed [ADC_WIDTH+1:0] prod_q_p1,
  output logic                        vld_p1,
  output logic                        last_p1
);

  localparam int MW = ADC_WIDTH + 2;

  logic signed [MW-1:0] ac;
  logic        [1:0]    eff_ph;
  logic        [1:0]    sgn;
  logic        [1:0]    p_d, p_q;
  logic signed [MW-1:0] prod_i_d, prod_i_q, prod_q_d, prod_q_q;
  logic                 vld_d, vld_q, last_d, last_q;

  always_comb begin
    // Two extra bits keep the difference and its negation in range.
    ac       = $signed({2'b00, adc_data_in}) - $signed({dc_subtractor[ADC_WIDTH], dc_subtractor});
    eff_ph   = p_q + lo_phase_ofs;
    sgn      = LO_SIGN_TBL[eff_ph];
    p_d      = p_q;
    prod_i_d = '0;
    prod_q_d = '0;
    vld_d    = 1'b0;
    last_d   = 1'b0;
    if (clr) begin
      p_d = '0;
    end else if (accept) begin
      p_d      = p_q + 2'd1;
      prod_i_d = sgn[1] ? -ac : ac;
      prod_q_d = sgn[0] ? -ac : ac;
      vld_d    = 1'b1;
      last_d   = last;
    end
  end

  // Stage 1: mixed products
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      p_q      <= '0;
      prod_i_q <= '0;
      prod_q_q <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      p_q      <= p_d;
      prod_i_q <= prod_i_d;
      prod_q_q <= prod_q_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
    end
  end

  assign prod_i_p1 = prod_i_q;
  assign prod_q_p1 = prod_q_q;
  assign vld_p1    = vld_q;
  assign last_p1   = last_q;

endmodule

// File: rtl/gnrl_dconv_accum.sv
// gnrl_dconv_accum: fs/4 quadrature downconverter with integrate-and-dump.
// Build option: GNRL_DCONV_SATURATE_EN - clamp the accumulators on overflow
// instead of wrapping; ovf is raised in both builds.
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   adc_data_in       unsigned ADC sample, qualified by adc_valid
//   dc_subtractor     signed DC offset removed from every sample
//   conv_en           enable; low returns to IDLE and clears all state
//   lo_phase_ofs      LO phase offset in 90 degree steps
//   decim_len         samples per block (0 behaves as 1), latched per block
//   out_i, out_q      signed block sums, held between dumps
//   out_valid         one-cycle pulse per completed block
//   ovf               sticky accumulator overflow flag
module gnrl_dconv_accum
  import gnrl_dconv_pkg::*;
#(
  parameter int ADC_WIDTH = 14,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic        [ADC_WIDTH-1:0] adc_data_in,
  input  logic                        adc_valid,
  input  logic signed [ADC_WIDTH:0]   dc_subtractor,
  input  logic                        conv_en,
  input  logic        [1:0]           lo_phase_ofs,
  input  logic        [LEN_WIDTH-1:0] decim_len,
  output logic signed [ACC_WIDTH-1:0] out_i,
  output logic signed [ACC_WIDTH-1:0] out_q,
  output logic                        out_valid,
  output logic                        ovf
);

  localparam int MW = ADC_WIDTH + 2;

  if (!acc_width_ok(ACC_WIDTH, ADC_WIDTH)) begin : g_width_chk
    $error("gnrl_dconv_accum: ACC_WIDTH must be at least ADC_WIDTH+2");
  end

`ifdef GNRL_DCONV_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  // Returns {overflow, sum}; the sum clamps or wraps depending on the build.
  function automatic logic [ACC_WIDTH:0] add_acc(input logic signed [ACC_WIDTH-1:0] a,
                                                 input logic signed [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH-1:0] s;
    logic                        ov;
    s  = a + b;
    ov = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
`ifdef GNRL_DCONV_SATURATE_EN
    if (ov) s = a[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
`endif
    return {ov, s};
  endfunction

  state_e                      state_d, state_q;
  logic        [LEN_WIDTH-1:0] cnt_d, cnt_q, len_d, len_q, len_norm, eff_len;
  logic                        accept, clr, last;
  logic signed [MW-1:0]        prod_i_p1, prod_q_p1;
  logic                        vld_p1, last_p1;
  logic signed [ACC_WIDTH-1:0] ext_i, ext_q;
  logic        [ACC_WIDTH:0]   add_i, add_q;
  logic signed [ACC_WIDTH-1:0] acc_inph_d, acc_inph_q, acc_quad_d, acc_quad_q;
  logic signed [ACC_WIDTH-1:0] dump_inph_d, dump_inph_q, dump_quad_d, dump_quad_q;
  logic                        dump_p2_d, dump_p2_q;
  logic signed [ACC_WIDTH-1:0] out_i_d, out_i_q, out_q_d, out_q_q;
  logic                        out_valid_d, out_valid_q, ovf_d, ovf_q;

  // Block counter: length is latched on the first sample of every block.
  always_comb begin
    clr      = !conv_en;
    accept   = (state_q == ST_RUN) && conv_en && adc_valid;
    len_norm = (decim_len == '0) ? LEN_WIDTH'(1) : decim_len;
    eff_len  = (cnt_q == '0) ? len_norm : len_q;
    last     = ({1'b0, cnt_q} + (LEN_WIDTH+1)'(1)) == {1'b0, eff_len};
    state_d  = conv_en ? ST_RUN : ST_IDLE;
    cnt_d    = cnt_q;
    len_d    = len_q;
    if (clr) begin
      cnt_d = '0;
      len_d = '0;
    end else if (accept) begin
      cnt_d = last ? '0 : cnt_q + LEN_WIDTH'(1);
      len_d = eff_len;
    end
  end

  gnrl_dconv_mixer #(
    .ADC_WIDTH(ADC_WIDTH)
  ) u_mixer (
    .CLK          (CLK),
    .RESET        (RESET),
    .clr          (clr),
    .accept       (accept),
    .last         (last),
    .adc_data_in  (adc_data_in),
    .dc_subtractor(dc_subtractor),
    .lo_phase_ofs (lo_phase_ofs),
    .prod_i_p1    (prod_i_p1),
    .prod_q_p1    (prod_q_p1),
    .vld_p1       (vld_p1),
    .last_p1      (last_p1)
  );

  always_comb begin
    ext_i       = ACC_WIDTH'(prod_i_p1);
    ext_q       = ACC_WIDTH'(prod_q_p1);
    add_i       = add_acc(acc_inph_q, ext_i);
    add_q       = add_acc(acc_quad_q, ext_q);
    acc_inph_d  = acc_inph_q;
    acc_quad_d  = acc_quad_q;
    dump_inph_d = dump_inph_q;
    dump_quad_d = dump_quad_q;
    dump_p2_d   = 1'b0;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    if (vld_p1) begin
      if (last_p1) begin
        // Final sample goes straight into the dump; the next block starts clean.
        dump_inph_d = add_i[ACC_WIDTH-1:0];
        dump_quad_d = add_q[ACC_WIDTH-1:0];
        acc_inph_d  = '0;
        acc_quad_d  = '0;
        dump_p2_d   = 1'b1;
      end else begin
        acc_inph_d  = add_i[ACC_WIDTH-1:0];
        acc_quad_d  = add_q[ACC_WIDTH-1:0];
      end
      if (add_i[ACC_WIDTH] || add_q[ACC_WIDTH]) ovf_d = 1'b1;
    end
    if (dump_p2_q) begin
      out_i_d     = dump_inph_q;
      out_q_d     = dump_quad_q;
      out_valid_d = 1'b1;
    end
    // Disabling drops any block in flight; the last published result stays.
    if (clr) begin
      acc_inph_d  = '0;
      acc_quad_d  = '0;
      dump_inph_d = '0;
      dump_quad_d = '0;
      dump_p2_d   = 1'b0;
      out_i_d     = out_i_q;
      out_q_d     = out_q_q;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end
  end

  // Stage 2: accumulate / dump, then publish
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      acc_inph_q  <= '0;
      acc_quad_q  <= '0;
      dump_inph_q <= '0;
      dump_quad_q <= '0;
      dump_p2_q   <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      acc_inph_q  <= acc_inph_d;
      acc_quad_q  <= acc_quad_d;
      dump_inph_q <= dump_inph_d;
      dump_quad_q <= dump_quad_d;
      dump_p2_q   <= dump_p2_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gnrl_dconv_accum.sv
// Directed bench for gnrl_dconv_accum: a 32-bit accumulator instance plus a
// 16-bit instance sharing the same stimulus for the overflow scenario.
module tb_gnrl_dconv_accum;

  logic               CLK = 1'b0;
  logic               RESET;
  logic        [13:0] adc_data_in;
  logic               adc_valid;
  logic signed [14:0] dc_subtractor;
  logic               conv_en;
  logic        [1:0]  lo_phase_ofs;
  logic        [15:0] decim_len;
  logic signed [31:0] out_i, out_q;
  logic               out_valid, ovf;
  logic signed [15:0] out_i16, out_q16;
  logic               out_valid16, ovf16;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic signed [31:0] cap_i[$];
  logic signed [31:0] cap_q[$];
  int                 cap_cyc[$];

`ifdef GNRL_DCONV_SATURATE_EN
  localparam logic signed [15:0] EXP16 = 16'sd32767;
`else
  localparam logic signed [15:0] EXP16 = -16'sd8;
`endif

  always #5 CLK = ~CLK;

  gnrl_dconv_accum #(.ADC_WIDTH(14), .ACC_WIDTH(32), .LEN_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .adc_data_in(adc_data_in), .adc_valid(adc_valid),
    .dc_subtractor(dc_subtractor), .conv_en(conv_en), .lo_phase_ofs(lo_phase_ofs),
    .decim_len(decim_len), .out_i(out_i), .out_q(out_q), .out_valid(out_valid), .ovf(ovf)
  );

  gnrl_dconv_accum #(.ADC_WIDTH(14), .ACC_WIDTH(16), .LEN_WIDTH(16)) dut16 (
    .CLK(CLK), .RESET(RESET), .adc_data_in(adc_data_in), .adc_valid(adc_valid),
    .dc_subtractor(dc_subtractor), .conv_en(conv_en), .lo_phase_ofs(lo_phase_ofs),
    .decim_len(decim_len), .out_i(out_i16), .out_q(out_q16), .out_valid(out_valid16), .ovf(ovf16)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (out_valid === 1'b1) begin
      cap_i.push_back(out_i);
      cap_q.push_back(out_q);
      cap_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    adc_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start_conv();
    adc_valid = 1'b0;
    conv_en   = 1'b0;
    tick();
    tick();
    conv_en = 1'b1;
    tick();
    cap_i.delete();
    cap_q.delete();
    cap_cyc.delete();
  endtask

  task automatic send(input logic [13:0] a, output int acc_cyc);
    adc_data_in = a;
    adc_valid   = 1'b1;
    tick();
    acc_cyc   = cyc;
    adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    adc_data_in = '0; adc_valid = 1'b0; dc_subtractor = '0; conv_en = 1'b0;
    lo_phase_ofs = '0; decim_len = '0;
    repeat (3) tick();
    checks++; if (out_i !== 32'sd0) begin errors++; $display("FAIL reset_out_i: got %0d expected 0", out_i); end
    checks++; if (out_q !== 32'sd0) begin errors++; $display("FAIL reset_out_q: got %0d expected 0", out_q); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (out_i16 !== 16'sd0) begin errors++; $display("FAIL reset_out_i16: got %0d expected 0", out_i16); end
    checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL reset_ovf16: got %b expected 0", ovf16); end
    RESET = 1'b0;
    tick();
  endtask

  // ac = +100, +100, -100, -100 with a 4-sample block
  task automatic test_mix(input logic [1:0] ofs, input int exp_i, input int exp_q);
    int a;
    start_conv();
    dc_subtractor = 15'sd8192;
    decim_len     = 16'd4;
    lo_phase_ofs  = ofs;
    send(14'd8292, a);
    send(14'd8292, a);
    send(14'd8092, a);
    send(14'd8092, a);
    idle(5);
    checks++; if (cap_i.size() != 1) begin errors++; $display("FAIL mix%0d_pulses: got %0d expected 1", ofs, cap_i.size()); end
    checks++; if (cap_i[0] !== exp_i) begin errors++; $display("FAIL mix%0d_i: got %0d expected %0d", ofs, cap_i[0], exp_i); end
    checks++; if (cap_q[0] !== exp_q) begin errors++; $display("FAIL mix%0d_q: got %0d expected %0d", ofs, cap_q[0], exp_q); end
    checks++; if (cap_cyc[0] != a + 2) begin errors++; $display("FAIL mix%0d_latency: got %0d expected %0d", ofs, cap_cyc[0] - a, 2); end
    checks++; if (out_i !== exp_i) begin errors++; $display("FAIL mix%0d_hold: got %0d expected %0d", ofs, out_i, exp_i); end
  endtask

  // decim_len 0 acts as 1; ac=+5 with gaps, LO phase runs across blocks
  task automatic test_decim_zero();
    int exp_i[6] = '{5, 5, -5, -5, 5, 5};
    int exp_q[6] = '{5, -5, -5, 5, 5, -5};
    int acc[6];
    start_conv();
    dc_subtractor = 15'sd8192;
    decim_len     = 16'd0;
    lo_phase_ofs  = 2'd0;
    for (int k = 0; k < 6; k++) begin
      send(14'd8197, acc[k]);
      tick();
    end
    idle(4);
    checks++; if (cap_i.size() != 6) begin errors++; $display("FAIL dz_pulses: got %0d expected 6", cap_i.size()); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (cap_i[k] !== exp_i[k]) begin errors++; $display("FAIL dz_i%0d: got %0d expected %0d", k, cap_i[k], exp_i[k]); end
      checks++; if (cap_q[k] !== exp_q[k]) begin errors++; $display("FAIL dz_q%0d: got %0d expected %0d", k, cap_q[k], exp_q[k]); end
      checks++; if (cap_cyc[k] != acc[k] + 2) begin errors++; $display("FAIL dz_lat%0d: got %0d expected 2", k, cap_cyc[k] - acc[k]); end
    end
  endtask

  // decim_len 4 -> 8 mid-block, contiguous samples ac = 1,2,4,...,2048
  task automatic test_back_to_back();
    int a;
    int a4, a12;
    start_conv();
    dc_subtractor = 15'sd8192;
    decim_len     = 16'd4;
    lo_phase_ofs  = 2'd0;
    a4 = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) decim_len = 16'd8;
      send(14'(8192 + (1 << k)), a);
      if (k == 3) a4 = a;
    end
    a12 = a;
    idle(5);
    checks++; if (cap_i.size() != 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", cap_i.size()); end
    checks++; if (cap_i[0] !== -32'sd9) begin errors++; $display("FAIL b2b_i0: got %0d expected -9", cap_i[0]); end
    checks++; if (cap_q[0] !== 32'sd3) begin errors++; $display("FAIL b2b_q0: got %0d expected 3", cap_q[0]); end
    checks++; if (cap_i[1] !== -32'sd2448) begin errors++; $display("FAIL b2b_i1: got %0d expected -2448", cap_i[1]); end
    checks++; if (cap_q[1] !== 32'sd816) begin errors++; $display("FAIL b2b_q1: got %0d expected 816", cap_q[1]); end
    checks++; if (cap_cyc[0] != a4 + 2) begin errors++; $display("FAIL b2b_lat0: got %0d expected 2", cap_cyc[0] - a4); end
    checks++; if (cap_cyc[1] != a12 + 2) begin errors++; $display("FAIL b2b_lat1: got %0d expected 2", cap_cyc[1] - a12); end
  endtask

  // 8 x 16383 with every effective phase 0: overflows a 16-bit accumulator
  task automatic test_overflow();
    int a;
    start_conv();
    dc_subtractor = 15'sd0;
    decim_len     = 16'd8;
    for (int k = 0; k < 8; k++) begin
      lo_phase_ofs = 2'((4 - (k % 4)) % 4);
      send(14'd16383, a);
    end
    idle(4);
    checks++; if (ovf16 !== 1'b1) begin errors++; $display("FAIL ovf16_flag: got %b expected 1", ovf16); end
    checks++; if (out_i16 !== EXP16) begin errors++; $display("FAIL ovf16_i: got %0d expected %0d", out_i16, EXP16); end
    checks++; if (out_q16 !== EXP16) begin errors++; $display("FAIL ovf16_q: got %0d expected %0d", out_q16, EXP16); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf32_flag: got %b expected 0", ovf); end
    checks++; if (out_i !== 32'sd131064) begin errors++; $display("FAIL ovf32_i: got %0d expected 131064", out_i); end
    checks++; if (out_q !== 32'sd131064) begin errors++; $display("FAIL ovf32_q: got %0d expected 131064", out_q); end
    conv_en = 1'b0;
    tick();
    checks++; if (ovf16 !== 1'b0) begin errors++; $display("FAIL ovf16_idle_clear: got %b expected 0", ovf16); end
    checks++; if (out_i16 !== EXP16) begin errors++; $display("FAIL ovf16_idle_hold: got %0d expected %0d", out_i16, EXP16); end
  endtask

  task automatic test_reset_mid_block();
    int a;
    start_conv();
    dc_subtractor = 15'sd8192;
    decim_len     = 16'd4;
    lo_phase_ofs  = 2'd0;
    send(14'd8292, a);
    send(14'd8292, a);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    idle(4);
    checks++; if (cap_i.size() != 0) begin errors++; $display("FAIL rst_mid_pulses: got %0d expected 0", cap_i.size()); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf: got %b expected 0", ovf); end
    send(14'd8292, a);
    send(14'd8292, a);
    send(14'd8092, a);
    send(14'd8092, a);
    idle(5);
    checks++; if (cap_i.size() != 1) begin errors++; $display("FAIL rst_next_pulses: got %0d expected 1", cap_i.size()); end
    checks++; if (cap_i[0] !== 32'sd400) begin errors++; $display("FAIL rst_next_i: got %0d expected 400", cap_i[0]); end
  endtask

  task automatic test_conv_drop();
    int a;
    start_conv();
    dc_subtractor = 15'sd8192;
    decim_len     = 16'd4;
    lo_phase_ofs  = 2'd0;
    send(14'd8292, a);
    send(14'd8292, a);
    conv_en = 1'b0;
    tick();
    conv_en = 1'b1;
    tick();
    send(14'd8292, a);
    send(14'd8292, a);
    send(14'd8092, a);
    send(14'd8092, a);
    idle(5);
    checks++; if (cap_i.size() != 1) begin errors++; $display("FAIL drop_pulses: got %0d expected 1", cap_i.size()); end
    checks++; if (cap_i[0] !== 32'sd400) begin errors++; $display("FAIL drop_i: got %0d expected 400", cap_i[0]); end
    // Second block completes, then the enable falls with its dump in flight.
    send(14'd8292, a);
    send(14'd8292, a);
    send(14'd8092, a);
    send(14'd8092, a);
    conv_en = 1'b0;
    tick();
    conv_en = 1'b1;
    idle(4);
    checks++; if (cap_i.size() != 1) begin errors++; $display("FAIL drop_dump_suppressed: got %0d pulses expected 1", cap_i.size()); end
    checks++; if (out_i !== 32'sd400) begin errors++; $display("FAIL drop_hold_i: got %0d expected 400", out_i); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL drop_ovf: got %b expected 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_mix(2'd0, 400, 0);
    test_mix(2'd1, 0, -400);
    test_mix(2'd2, -400, 0);
    test_decim_zero();
    test_back_to_back();
    test_overflow();
    test_reset_mid_block();
    test_conv_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
